// File: rtl/router_pkg.sv
// router_pkg: shared router sizing defaults and port naming
package router_pkg;
  localparam int NUM_PORTS = 5;
  localparam int NUM_VCS = 4;
  localparam int PORT_W = $clog2(NUM_PORTS);
  localparam int VC_W = $clog2(NUM_VCS);
  typedef enum logic [2:0] {LOCAL, NORTH, EAST, SOUTH, WEST} port_e;
endpackage

// File: rtl/rr_arbiter_upd.sv
// rr_arbiter_upd: round-robin arbiter whose pointer advances past the winner only when upd_en is high; ports clk, reset (async active-low), req, upd_en, one-hot grant
module rr_arbiter_upd #(
  parameter int N = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] req,
  input  logic         upd_en,
  output logic [N-1:0] grant
);
  localparam int W = N > 1 ? $clog2(N) : 1;
  logic [W-1:0] ptr;
  logic [W-1:0] gidx;
  logic         found;
  always_comb begin
    grant = '0;
    gidx = '0;
    found = 1'b0;
    for (int i = 0; i < N; i++) begin
      int k;
      k = (int'(ptr) + i) % N;
      if (!found && req[k]) begin
        grant[k] = 1'b1;
        gidx = W'(k);
        found = 1'b1;
      end
    end
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) ptr <= '0;
    else if (upd_en && found) ptr <= gidx == W'(N - 1) ? '0 : gidx + 1'b1;
endmodule

// File: rtl/switch_allocator.sv
// switch_allocator: separable input-first VC switch allocator; sa_req/sa_out_port in, registered in_grant_valid/in_grant_vc per input and out_grant_valid/out_sel per output, async active-low reset
module switch_allocator #(
  parameter int NUM_PORTS = router_pkg::NUM_PORTS,
  parameter int NUM_VCS = router_pkg::NUM_VCS,
  parameter int PORT_W = $clog2(NUM_PORTS),
  parameter int VC_W = $clog2(NUM_VCS)
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [NUM_PORTS*NUM_VCS-1:0]        sa_req,
  input  logic [NUM_PORTS*NUM_VCS*PORT_W-1:0] sa_out_port,
  output logic [NUM_PORTS-1:0]                in_grant_valid,
  output logic [NUM_PORTS*VC_W-1:0]           in_grant_vc,
  output logic [NUM_PORTS-1:0]                out_grant_valid,
  output logic [NUM_PORTS*PORT_W-1:0]         out_sel
);
  import router_pkg::*;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             rq;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0][PORT_W-1:0] op;
  logic [NUM_PORTS-1:0][NUM_VCS-1:0]             s1_req, s1_gnt;
  logic [NUM_PORTS-1:0][VC_W-1:0]                s1_vc;
  logic [NUM_PORTS-1:0][PORT_W-1:0]              s1_port;
  logic [NUM_PORTS-1:0]                          s1_valid;
  logic [NUM_PORTS-1:0][NUM_PORTS-1:0]           s2_req, s2_gnt;
  logic [NUM_PORTS-1:0]                          in_win, out_v_d;
  logic [NUM_PORTS-1:0][VC_W-1:0]                in_vc_d, in_vc_q;
  logic [NUM_PORTS-1:0][PORT_W-1:0]              out_sel_d, out_sel_q;
  assign rq = sa_req;
  assign op = sa_out_port;
  always_comb begin
    s1_req = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int v = 0; v < NUM_VCS; v++)
        s1_req[p][v] = rq[p][v] && ({1'b0, op[p][v]} < (PORT_W + 1)'(NUM_PORTS));
  end
  // Stage-1 pointers move only on a final grant, so a VC that loses stage 2 keeps priority
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_s1
    rr_arbiter_upd #(.N(NUM_VCS)) u_arb (
      .clk(clk), .reset(reset), .req(s1_req[p]), .upd_en(in_win[p]), .grant(s1_gnt[p])
    );
  end
  always_comb begin
    s1_vc = '0;
    s1_port = '0;
    s2_req = '0;
    for (int p = 0; p < NUM_PORTS; p++)
      for (int v = 0; v < NUM_VCS; v++)
        if (s1_gnt[p][v]) begin
          s1_vc[p] = VC_W'(v);
          s1_port[p] = op[p][v];
        end
    for (int p = 0; p < NUM_PORTS; p++) s1_valid[p] = |s1_gnt[p];
    for (int o = 0; o < NUM_PORTS; o++)
      for (int p = 0; p < NUM_PORTS; p++)
        s2_req[o][p] = s1_valid[p] && s1_port[p] == PORT_W'(o);
  end
  for (genvar o = 0; o < NUM_PORTS; o++) begin : g_s2
    rr_arbiter_upd #(.N(NUM_PORTS)) u_arb (
      .clk(clk), .reset(reset), .req(s2_req[o]), .upd_en(1'b1), .grant(s2_gnt[o])
    );
  end
  always_comb begin
    in_win = '0;
    out_v_d = '0;
    out_sel_d = '0;
    for (int o = 0; o < NUM_PORTS; o++) begin
      out_v_d[o] = |s2_gnt[o];
      for (int p = 0; p < NUM_PORTS; p++)
        if (s2_gnt[o][p]) begin
          in_win[p] = 1'b1;
          out_sel_d[o] = PORT_W'(p);
        end
    end
    for (int p = 0; p < NUM_PORTS; p++) in_vc_d[p] = in_win[p] ? s1_vc[p] : '0;
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      in_grant_valid <= '0;
      in_vc_q <= '0;
      out_grant_valid <= '0;
      out_sel_q <= '0;
    end else begin
      in_grant_valid <= in_win;
      in_vc_q <= in_vc_d;
      out_grant_valid <= out_v_d;
      out_sel_q <= out_sel_d;
    end
  assign in_grant_vc = in_vc_q;
  assign out_sel = out_sel_q;
endmodule

// File: tb/tb_switch_allocator.sv
// tb_switch_allocator: scoreboard bench for switch_allocator
module tb_switch_allocator;
  typedef struct packed {
    logic [4:0]  iv;
    logic [9:0]  ivc;
    logic [4:0]  ov;
    logic [14:0] os;
  } exp_t;
  logic        clk = 0;
  logic        rst_n = 0;
  logic [19:0] sa_req = '0;
  logic [59:0] sa_out_port = '0;
  logic [4:0]  in_grant_valid, out_grant_valid;
  logic [9:0]  in_grant_vc;
  logic [14:0] out_sel;
  exp_t q[$];
  exp_t e, g;
  int tests = 0, fails = 0;
  int m_ip[5], m_op[5];
  switch_allocator dut (
    .clk(clk), .reset(rst_n), .sa_req(sa_req), .sa_out_port(sa_out_port),
    .in_grant_valid(in_grant_valid), .in_grant_vc(in_grant_vc),
    .out_grant_valid(out_grant_valid), .out_sel(out_sel)
  );
  always #5 clk = ~clk;
  function automatic exp_t dut_out();
    return {in_grant_valid, in_grant_vc, out_grant_valid, out_sel};
  endfunction
  function automatic exp_t add(exp_t x, int p, int v, int o);
    x.iv[p] = 1'b1;
    x.ivc[p*2+:2] = 2'(v);
    x.ov[o] = 1'b1;
    x.os[o*3+:3] = 3'(p);
    return x;
  endfunction
  task automatic set_req(int p, int v, int o);
    sa_req[p*4+v] = 1'b1;
    sa_out_port[(p*4+v)*3+:3] = 3'(o);
  endtask
  task automatic clear_req();
    sa_req = '0;
    sa_out_port = '0;
  endtask
  task automatic do_reset();
    @(negedge clk);
    clear_req();
    rst_n = 0;
    @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 5; i++) begin
      m_ip[i] = 0;
      m_op[i] = 0;
    end
  endtask
  task automatic model_step(output exp_t x);
    int w1[5];
    x = '0;
    for (int p = 0; p < 5; p++) begin
      w1[p] = -1;
      for (int k = 0; k < 4; k++) begin
        int v;
        v = (m_ip[p] + k) % 4;
        if (w1[p] < 0 && sa_req[p*4+v] && sa_out_port[(p*4+v)*3+:3] < 3'd5) w1[p] = v;
      end
    end
    for (int o = 0; o < 5; o++)
      for (int k = 0; k < 5; k++) begin
        int p;
        p = (m_op[o] + k) % 5;
        if (w1[p] >= 0 && int'(sa_out_port[(p*4+w1[p])*3+:3]) == o) begin
          x = add(x, p, w1[p], o);
          m_op[o] = (p + 1) % 5;
          m_ip[p] = (w1[p] + 1) % 4;
          break;
        end
      end
  endtask
  task automatic test_reset();
    #1;
    tests++;
    if (dut_out() !== exp_t'(0)) begin
      fails++;
      $display("FAIL reset_state: got %h want 0", dut_out());
    end
    @(negedge clk);
    rst_n = 1;
    repeat (5) begin
      q.push_back(exp_t'(0));
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e) begin
        fails++;
        $display("FAIL idle: got %h want %h", dut_out(), e);
      end
    end
    @(negedge clk);
    set_req(2, 3, 4);
    @(posedge clk); #1;
    tests++;
    if (in_grant_valid !== 5'b00100) begin
      fails++;
      $display("FAIL pre_async_reset: got %b want 00100", in_grant_valid);
    end
    #3 rst_n = 0;
    #1;
    tests++;
    if (dut_out() !== exp_t'(0)) begin
      fails++;
      $display("FAIL async_reset: got %h want 0", dut_out());
    end
    @(negedge clk);
    clear_req();
    rst_n = 1;
  endtask
  task automatic test_single();
    do_reset();
    set_req(2, 3, 4);
    repeat (3) begin
      q.push_back(add(exp_t'(0), 2, 3, 4));
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e) begin
        fails++;
        $display("FAIL single: got %h want %h", dut_out(), e);
      end
    end
  endtask
  task automatic test_input_contention();
    do_reset();
    for (int v = 0; v < 4; v++) set_req(0, v, v + 1);
    for (int i = 0; i < 5; i++) begin
      q.push_back(add(exp_t'(0), 0, i % 4, i % 4 + 1));
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e) begin
        fails++;
        $display("FAIL input_contention[%0d]: got %h want %h", i, dut_out(), e);
      end
    end
  endtask
  task automatic test_output_contention();
    do_reset();
    for (int p = 0; p < 5; p++) set_req(p, 0, 1);
    for (int i = 0; i < 6; i++) begin
      q.push_back(add(exp_t'(0), i % 5, 0, 1));
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e || $countones(in_grant_valid) != 1) begin
        fails++;
        $display("FAIL output_contention[%0d]: got %h want %h", i, dut_out(), e);
      end
    end
  endtask
  task automatic test_islip_hold();
    exp_t steps[3];
    do_reset();
    set_req(0, 3, 3);
    steps[0] = add(exp_t'(0), 0, 3, 3);
    steps[1] = add(exp_t'(0), 1, 0, 3);
    steps[2] = add(exp_t'(0), 0, 0, 3);
    for (int i = 0; i < 3; i++) begin
      q.push_back(steps[i]);
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e) begin
        fails++;
        $display("FAIL islip_hold[%0d]: got %h want %h", i, dut_out(), e);
      end
      @(negedge clk);
      clear_req();
      if (i == 0) begin
        set_req(0, 0, 3);
        set_req(0, 1, 3);
        set_req(1, 0, 3);
      end else begin
        set_req(0, 0, 3);
        set_req(0, 1, 3);
      end
    end
  endtask
  task automatic test_illegal_port();
    do_reset();
    set_req(0, 1, 7);
    set_req(3, 2, 5);
    for (int i = 0; i < 4; i++) begin
      q.push_back(i < 3 ? exp_t'(0) : add(exp_t'(0), 0, 0, 2));
      @(posedge clk); #1;
      e = q.pop_front();
      tests++;
      if (dut_out() !== e) begin
        fails++;
        $display("FAIL illegal_port[%0d]: got %h want %h", i, dut_out(), e);
      end
      if (i == 2) begin
        @(negedge clk);
        set_req(0, 0, 2);
        set_req(0, 2, 3);
      end
    end
  endtask
  task automatic test_random();
    do_reset();
    for (int i = 0; i < 10000; i++) begin
      sa_req = 20'($urandom);
      sa_out_port = {28'($urandom), 32'($urandom)};
      model_step(e);
      q.push_back(e);
      @(posedge clk); #1;
      e = q.pop_front();
      g = dut_out();
      tests++;
      if (g !== e) begin
        fails++;
        $display("FAIL random[%0d]: got %h want %h", i, g, e);
      end
      tests++;
      if ($countones(in_grant_valid) != $countones(out_grant_valid)) begin
        fails++;
        $display("FAIL popcount[%0d]: in %b out %b", i, in_grant_valid, out_grant_valid);
      end
      @(negedge clk);
    end
    clear_req();
  endtask
  initial begin
    test_reset();
    test_single();
    test_input_contention();
    test_output_contention();
    test_islip_hold();
    test_illegal_port();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/switch_allocator.md
# switch_allocator

Separable input-first switch allocator for the virtual channel router. Each cycle it matches input-VC requests to crossbar output ports so that each input port and each output port is used at most once. It uses two stages of round-robin arbitration with grant-qualified pointer updates. Sits between the VC allocation stage and the crossbar; its registered grants drive crossbar selects and input-buffer reads.

## Interface
Parameters:
- NUM_PORTS, 5, router ports (inputs = outputs)
- NUM_VCS, 4, virtual channels per input port
- PORT_W, $clog2(NUM_PORTS), output-port index width
- VC_W, $clog2(NUM_VCS), VC index width

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-low reset
- sa_req  in  NUM_PORTS*NUM_VCS  bit p*NUM_VCS+v: VC v of input p has a flit and downstream credit
- sa_out_port  in  NUM_PORTS*NUM_VCS*PORT_W  requested output port per input VC, same indexing
- in_grant_valid  out  NUM_PORTS  input p won a crossbar slot
- in_grant_vc  out  NUM_PORTS*VC_W  winning VC of input p
- out_grant_valid  out  NUM_PORTS  output o is driven this cycle
- out_sel  out  NUM_PORTS*PORT_W  input port driving output o

## Operation
- Stage 1, one arbiter per input p (NUM_VCS wide): among VCs with sa_req set and sa_out_port < NUM_PORTS, pick the first at or after pointer ip_ptr[p], wrapping.
- Stage 2, one arbiter per output o (NUM_PORTS wide): among inputs whose stage-1 winner targets o, pick the first at or after op_ptr[o], wrapping.
- Final grant for input p: its stage-1 winner also wins stage 2.
- Pointer update, iSLIP rule:
  - ip_ptr[p] ← (winning VC + 1) mod NUM_VCS only on a final grant for p.
  - Otherwise ip_ptr[p] holds, including when p loses stage 2.
  - op_ptr[o] ← (granted input + 1) mod NUM_PORTS only when o grants.
- Requests with sa_out_port ≥ NUM_PORTS are ignored. They are never granted and do not move pointers.
- No requests: all valid outputs 0; pointers hold.
- in_grant_vc/out_sel are 0 whenever the matching valid is 0.
- Invariants: at most one in_grant_valid per input and one out_grant_valid per output. The popcounts of in_grant_valid and out_grant_valid are equal. out_sel[o] = p iff in_grant_valid[p] and the stage-1 winner of p targets o.

## Timing
- Combinational allocation from sa_req/sa_out_port; all outputs registered. A request sampled at edge N appears as a grant after edge N, valid during cycle N+1.
- Pointers update on the same edge that registers the grant.
- Requesters drop or change sa_req the cycle after seeing their grant. The allocator does not track in-flight grants.
- Reset assertion, asynchronous and at any time including mid-allocation:
  - All outputs → 0 immediately.
  - All ip_ptr/op_ptr → 0.
- First grant possible at the first rising edge after reset deasserts.

## Structure
- Shared package router_pkg: NUM_PORTS/NUM_VCS defaults, PORT_W/VC_W, port enum (LOCAL, NORTH, EAST, SOUTH, WEST = 0..4).
- Sub-module rr_arbiter_upd: parameter N.
  - Ports: clk, reset (async active-low), req[N], upd_en, grant one-hot [N].
  - Grant is combinational from req and an internal pointer.
  - The pointer advances past the granted index only when upd_en is high.
- Instantiate NUM_PORTS stage-1 arbiters (N = NUM_VCS) and NUM_PORTS stage-2 arbiters (N = NUM_PORTS). Glue, one-hot-to-index encoders and output registers live in switch_allocator.

## Test plan
Defaults (5 ports, 4 VCs).
1. Reset, then all sa_req=0 for 5 cycles → all valids 0, pointers 0. Assert reset low mid-grant → outputs clear without a clock edge.
2. Single request: input 2 VC 3 to output 4, held 3 cycles.
   - Each following cycle: in_grant_valid=00100, in_grant_vc[2]=3, out_grant_valid=10000, out_sel[4]=2.
3. Input-port contention: input 0 VCs 0–3 all to distinct outputs 1–4, held.
   - Granted VC sequence 0,1,2,3,0.
4. Output contention: inputs 0–4 each VC 0 to output 1, held.
   - out_sel[1] sequence 0,1,2,3,4,0.
   - Exactly one in_grant_valid per cycle.
5. iSLIP hold:
   - Input 0 VC0 and VC1 target output 3. Input 1 VC0 targets output 3. op_ptr[3]=1.
   - Input 1 wins; ip_ptr[0] stays 0, so input 0 VC0 is granted next cycle once input 1 drops.
6. Illegal port: sa_out_port=7 with sa_req set → never granted, pointers unchanged. Random legal traffic for 10k cycles checks the one-per-port invariants.
